// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: control-transfer opcodes, branch
// condition encodings and the branch sequencer state encoding.
package cpu_ctrl_pkg;

  // IR[31:27] opcodes of the control-transfer instructions
  localparam logic [4:0] OP_BR  = 5'b10011;
  localparam logic [4:0] OP_JR  = 5'b10100;
  localparam logic [4:0] OP_JAL = 5'b10101;

  // IR[20:19] branch condition encodings evaluated by the CON FF
  localparam logic [1:0] ZR = 2'b00;
  localparam logic [1:0] NZ = 2'b01;
  localparam logic [1:0] PL = 2'b10;
  localparam logic [1:0] MI = 2'b11;

  // Sequencer steps; encodings 6 and 7 are unused and recover to IDLE
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BR_COND  = 3'd1,
    BR_TGT   = 3'd2,
    JR_LOAD  = 3'd3,
    JAL_LINK = 3'd4,
    JAL_LOAD = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count updates on the clock edge after inc; clear wins over inc.
// No backpressure; inc at saturation is silently absorbed.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, increment below all-ones, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/branch_seq.sv
// Sequences the T3..T5 control steps of br/jr/jal and keeps branch statistics.
// Latency: br 2 cycles, jr 1 cycle, jal 2 cycles from accepted start to done.
// No backpressure: start is accepted only when idle, dropped while busy.
module branch_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [1:0]       cond,
  input  logic             CONFF,
  output logic             Gra,
  output logic             Grb,
  output logic             R15_sel,
  output logic             Rout,
  output logic             R_in,
  output logic             PC_out,
  output logic             PC_in,
  output logic             CON_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  state_t     state_q;
  state_t     state_d;
  logic       taken_q;
  logic       taken_d;
  logic [1:0] cond_q;
  logic       br_inc;
  logic       taken_inc;

  // next-state and taken-flag update; only IDLE samples start/opcode
  always_comb begin
    state_d = IDLE;
    taken_d = taken_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (opcode)
            OP_BR:   state_d = BR_COND;
            OP_JR:   state_d = JR_LOAD;
            OP_JAL:  state_d = JAL_LINK;
            default: state_d = IDLE;
          endcase
        end
      end
      BR_COND:  state_d = BR_TGT;
      BR_TGT:   taken_d = CONFF;
      JR_LOAD:  taken_d = 1'b1;
      JAL_LINK: state_d = JAL_LOAD;
      JAL_LOAD: taken_d = 1'b1;
      default:  state_d = IDLE;
    endcase
  end

  // state, taken flag and latched condition; reset aborts any sequence at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      cond_q  <= ZR;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      if ((state_q == IDLE) && start && (opcode == OP_BR)) begin
        cond_q <= cond;
      end
    end
  end

  // Moore decode of the control strobes; only PC_in in BR_TGT looks at CONFF
  always_comb begin
    Gra     = 1'b0;
    Grb     = 1'b0;
    R15_sel = 1'b0;
    Rout    = 1'b0;
    R_in    = 1'b0;
    PC_out  = 1'b0;
    PC_in   = 1'b0;
    CON_in  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      BR_COND: begin
        Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; busy = 1'b1;
      end
      BR_TGT: begin
        Grb = 1'b1; Rout = 1'b1; PC_in = CONFF; busy = 1'b1; done = 1'b1;
      end
      JR_LOAD: begin
        Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; busy = 1'b1; done = 1'b1;
      end
      JAL_LINK: begin
        PC_out = 1'b1; R15_sel = 1'b1; R_in = 1'b1; busy = 1'b1;
      end
      JAL_LOAD: begin
        Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; busy = 1'b1; done = 1'b1;
      end
      default: ;
    endcase
  end

  assign taken     = taken_q;
  assign br_inc    = (state_q == BR_TGT);
  assign taken_inc = br_inc & CONFF;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk     (clk),
    .rst     (reset),
    .clear   (1'b0),
    .inc     (br_inc),
    .count_o (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst     (reset),
    .clear   (1'b0),
    .inc     (taken_inc),
    .count_o (taken_count)
  );

  // a busy step must drive the bus from exactly one source
  a_one_driver: assert property (@(posedge clk) disable iff (reset)
    busy |-> (Rout ^ PC_out));

  // the latched branch condition stays defined for statistics observers
  a_cond_known: assert property (@(posedge clk) disable iff (reset)
    (state_q == BR_TGT) |-> !$isunknown(cond_q));

endmodule

// File: tb/tb_branch_seq.sv
module tb_branch_seq;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  opcode;
  logic [1:0]  cond;
  logic        CONFF;

  logic        Gra, Grb, R15_sel, Rout, R_in, PC_out, PC_in, CON_in, busy, done, taken;
  logic [15:0] br_count, taken_count;

  // narrow-counter twin, fed identical stimulus, used to reach saturation quickly
  logic        s_Gra, s_Grb, s_R15_sel, s_Rout, s_R_in, s_PC_out, s_PC_in, s_CON_in;
  logic        s_busy, s_done, s_taken;
  logic [1:0]  s_br_count, s_taken_count;

  int n_assert = 0;
  int n_fail   = 0;

  // control vector bit positions: {Gra,Grb,R15_sel,Rout,R_in,PC_out,PC_in,CON_in,busy,done}
  localparam logic [9:0] C_GRA   = 10'b1000000000;
  localparam logic [9:0] C_GRB   = 10'b0100000000;
  localparam logic [9:0] C_R15   = 10'b0010000000;
  localparam logic [9:0] C_ROUT  = 10'b0001000000;
  localparam logic [9:0] C_RIN   = 10'b0000100000;
  localparam logic [9:0] C_PCOUT = 10'b0000010000;
  localparam logic [9:0] C_PCIN  = 10'b0000001000;
  localparam logic [9:0] C_CONIN = 10'b0000000100;
  localparam logic [9:0] C_BUSY  = 10'b0000000010;
  localparam logic [9:0] C_DONE  = 10'b0000000001;

  localparam logic [9:0] V_BR_COND  = C_GRA | C_ROUT | C_CONIN | C_BUSY;
  localparam logic [9:0] V_BR_TGT_N = C_GRB | C_ROUT | C_BUSY | C_DONE;
  localparam logic [9:0] V_BR_TGT_T = C_GRB | C_ROUT | C_PCIN | C_BUSY | C_DONE;
  localparam logic [9:0] V_LOAD     = C_GRA | C_ROUT | C_PCIN | C_BUSY | C_DONE;
  localparam logic [9:0] V_JAL_LINK = C_PCOUT | C_R15 | C_RIN | C_BUSY;

  logic [9:0] ctl;
  assign ctl = {Gra, Grb, R15_sel, Rout, R_in, PC_out, PC_in, CON_in, busy, done};

  branch_seq #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .cond(cond), .CONFF(CONFF),
    .Gra(Gra), .Grb(Grb), .R15_sel(R15_sel), .Rout(Rout), .R_in(R_in), .PC_out(PC_out),
    .PC_in(PC_in), .CON_in(CON_in), .busy(busy), .done(done), .taken(taken),
    .br_count(br_count), .taken_count(taken_count)
  );

  branch_seq #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .cond(cond), .CONFF(CONFF),
    .Gra(s_Gra), .Grb(s_Grb), .R15_sel(s_R15_sel), .Rout(s_Rout), .R_in(s_R_in),
    .PC_out(s_PC_out), .PC_in(s_PC_in), .CON_in(s_CON_in), .busy(s_busy), .done(s_done),
    .taken(s_taken), .br_count(s_br_count), .taken_count(s_taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 5'b00000;
    cond   = 2'b00;
    CONFF  = 1'b0;
    tick();
    tick();
    chk("reset_ctl", ctl, 10'd0);
    chk("reset_taken", taken, 1'b0);
    chk("reset_br_count", br_count, 16'd0);
    chk("reset_taken_count", taken_count, 16'd0);
    reset = 1'b0;
    tick();

    // reset during BR_TGT drops PC_in immediately and nothing is counted
    start = 1'b1; opcode = OP_BR; cond = ZR; CONFF = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid_br_cond", ctl, V_BR_COND);
    tick();
    chk("rst_mid_br_tgt", ctl, V_BR_TGT_T);
    reset = 1'b1;
    #1;
    chk("rst_mid_pcin_drop", ctl, 10'd0);
    tick();
    chk("rst_mid_taken", taken, 1'b0);
    chk("rst_mid_br_count", br_count, 16'd0);
    chk("rst_mid_taken_count", taken_count, 16'd0);
    reset = 1'b0;
    tick();

    // brzr taken
    start = 1'b1; opcode = OP_BR; cond = ZR; CONFF = 1'b1;
    tick();
    start = 1'b0;
    chk("brzr_cycle1", ctl, V_BR_COND);
    tick();
    chk("brzr_cycle2", ctl, V_BR_TGT_T);
    tick();
    chk("brzr_idle", ctl, 10'd0);
    chk("brzr_taken", taken, 1'b1);
    chk("brzr_br_count", br_count, 16'd1);
    chk("brzr_taken_count", taken_count, 16'd1);

    // brnz not taken
    start = 1'b1; opcode = OP_BR; cond = NZ; CONFF = 1'b0;
    tick();
    start = 1'b0;
    chk("brnz_cycle1", ctl, V_BR_COND);
    tick();
    chk("brnz_cycle2", ctl, V_BR_TGT_N);
    tick();
    chk("brnz_idle", ctl, 10'd0);
    chk("brnz_taken", taken, 1'b0);
    chk("brnz_br_count", br_count, 16'd2);
    chk("brnz_taken_count", taken_count, 16'd1);

    // jal then jr straight after
    start = 1'b1; opcode = OP_JAL;
    tick();
    start = 1'b0;
    chk("jal_cycle1", ctl, V_JAL_LINK);
    tick();
    chk("jal_cycle2", ctl, V_LOAD);
    tick();
    chk("jal_taken", taken, 1'b1);
    chk("jal_idle", ctl, 10'd0);
    start = 1'b1; opcode = OP_JR;
    tick();
    start = 1'b0;
    chk("jr_cycle1", ctl, V_LOAD);
    tick();
    chk("jr_idle", ctl, 10'd0);
    chk("jr_taken", taken, 1'b1);
    chk("jump_br_count", br_count, 16'd2);
    chk("jump_taken_count", taken_count, 16'd1);

    // second start during BR_COND is ignored and the br completes
    start = 1'b1; opcode = OP_BR; cond = PL; CONFF = 1'b0;
    tick();
    opcode = OP_JR;
    chk("busy_cycle1", ctl, V_BR_COND);
    tick();
    chk("busy_cycle2", ctl, V_BR_TGT_N);
    start = 1'b0;
    tick();
    chk("busy_idle", ctl, 10'd0);
    chk("busy_taken", taken, 1'b0);
    chk("busy_br_count", br_count, 16'd3);
    chk("busy_taken_count", taken_count, 16'd1);

    // illegal opcode is dropped
    start = 1'b1; opcode = 5'b00000;
    tick();
    start = 1'b0;
    chk("illegal_cycle1", ctl, 10'd0);
    tick();
    chk("illegal_cycle2", ctl, 10'd0);
    chk("illegal_taken", taken, 1'b0);

    // narrow twin already holds br_count at its maximum; taken_count climbs to it
    chk("sat_pre_br", s_br_count, 2'd3);
    chk("sat_pre_taken", s_taken_count, 2'd1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; opcode = OP_BR; cond = MI; CONFF = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("sat_run_pcin", ctl, V_BR_TGT_T);
      tick();
      chk("sat_br_hold", s_br_count, 2'd3);
      chk("sat_taken", s_taken_count, (i == 0) ? 2'd2 : 2'd3);
      chk("sat_wide_br", br_count, 16'(4 + i));
      chk("sat_wide_taken", taken_count, 16'(2 + i));
    end
    chk("sat_taken_flag", s_taken, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Downstream consumer of the CON FF in the Phase 2 datapath.
- Sequences the T3..T5 control steps for br (brzr/brnz/brpl/brmi), jr and jal.
- Drives CON_in so the CON FF evaluates Ra against IR[20:19], then uses the latched CONFF to gate the PC load.
- Keeps saturating branch statistics for the test bench and the single-step monitor.

Parameters:
- CNT_W, 16, width of the branch and taken-branch counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears state and counters immediately.
- start  in  1  one-cycle pulse from the control unit in T2 when the instruction is a control-transfer op; ignored unless busy=0.
- opcode  in  5  IR[31:27], sampled on the accepted start.
- cond  in  2  IR[20:19], sampled on the accepted start; exported for statistics only (the CON FF reads IR directly).
- CONFF  in  1  output of the CON FF.
- Gra  out  1  select Ra field onto the register-file address.
- Grb  out  1  select Rb field.
- R15_sel  out  1  force register address 15 (jal link register).
- Rout  out  1  selected register drives the bus.
- R_in  out  1  selected register loads from the bus.
- PC_out  out  1  PC drives the bus.
- PC_in  out  1  PC loads from the bus.
- CON_in  out  1  CON FF enable.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse in the final step of a sequence.
- taken  out  1  registered; 1 if the last completed sequence loaded PC.
- br_count  out  CNT_W  completed br sequences, saturating.
- taken_count  out  CNT_W  br sequences with PC loaded, saturating.

Behaviour:
- Reset values:
  - All control outputs 0; busy=0, done=0, taken=0.
  - br_count=0, taken_count=0; state=IDLE.
- Opcode constants: OP_BR=5'b10011, OP_JR=5'b10100, OP_JAL=5'b10101.
- IDLE:
  - start with OP_BR -> BR_COND; start with OP_JR -> JR_LOAD; start with OP_JAL -> JAL_LINK.
  - start with any other opcode is dropped: no outputs, stays IDLE.
- BR_COND (T3):
  - Gra=1, Rout=1, CON_in=1, busy=1.
  - The CON FF latches at the end of this cycle. -> BR_TGT.
- BR_TGT (T4):
  - Grb=1, Rout=1, PC_in=CONFF, busy=1, done=1.
  - taken<=CONFF; br_count+=1; taken_count+=CONFF. -> IDLE.
- JR_LOAD (T3):
  - Gra=1, Rout=1, PC_in=1, busy=1, done=1; taken<=1. -> IDLE.
- JAL_LINK (T3):
  - PC_out=1, R15_sel=1, R_in=1, busy=1. -> JAL_LOAD.
- JAL_LOAD (T4):
  - Gra=1, Rout=1, PC_in=1, busy=1, done=1; taken<=1. -> IDLE.
- Control outputs are combinational from the state register (Moore), except PC_in in BR_TGT, which depends on CONFF.
- Exactly one bus driver (Rout or PC_out) is active per cycle; any other combination is a design error.
- Latency: br 2 cycles, jr 1 cycle, jal 2 cycles from start to done.
- start while busy=1 is ignored; opcode and cond are not resampled.
- Counters saturate at all-ones and never wrap; jr and jal do not touch the counters.
- reset asserted mid-sequence returns to IDLE in the same cycle and deasserts PC_in/R_in at once; no partial PC or R15 write may complete after the reset edge.
- Unreachable state encodings recover to IDLE with all outputs 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the opcode constants;
  - the state enum {IDLE, BR_COND, BR_TGT, JR_LOAD, JAL_LINK, JAL_LOAD};
  - the cond encodings ZR=2'b00, NZ=2'b01, PL=2'b10, MI=2'b11.
- One natural sub-module: sat_counter (parameter W; inc, clear), instantiated twice for the statistics.

Test Plan:
- reset mid-sequence: start OP_BR, assert reset during BR_TGT -> PC_in drops in the same cycle; state IDLE, counters 0, taken=0.
- brzr taken: start OP_BR, cond=00, CONFF=1 in BR_TGT -> CON_in high in cycle 1; Grb/Rout/PC_in/done high in cycle 2; taken=1, br_count=1, taken_count=1.
- brnz not taken: start OP_BR, cond=01, CONFF=0 -> PC_in never asserts; done pulses in cycle 2; taken=0, br_count=1, taken_count unchanged.
- jal then jr:
  - jal: cycle 1 PC_out/R15_sel/R_in=1; cycle 2 Gra/Rout/PC_in=1.
  - jr immediately after: single-cycle PC_in.
  - Counters unchanged; taken=1.
- start while busy, plus illegal opcode:
  - A second start during BR_COND is ignored; the sequence completes normally.
  - start with opcode 5'b00000 -> no outputs, busy stays 0.
- saturation: force br_count/taken_count to 16'hFFFE, run three taken br sequences -> both counters hold at 16'hFFFF.
